// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between the Z80 bus
// and the video fetcher; video has priority, CPU is bounded by a starve limit.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              mreq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_oe,
  output logic              wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_ack,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, VRD, VCAP, CRD, CCAP, CWR
  } state_t;

  state_t        state, state_d;
  logic [SW-1:0] starve_cnt;
  logic          cpu_done;
  logic          cpu_req, cpu_busy, cpu_pend;
  logic          vid_gnt, crd_gnt, cwr_gnt;

  assign cpu_req  = cs & ~mreq_n & (~rd_n | ~wr_n);
  assign cpu_busy = (state == CRD) | (state == CCAP)
                  | (state == CWR);
  assign cpu_pend = cpu_req & ~cpu_done & ~cpu_busy;
  assign wait_n   = ~(cpu_req & ~cpu_done);
  assign cpu_oe   = cs & ~rd_n & ~mreq_n & cpu_done;

  always_comb begin
    state_d = state;
    vid_gnt = 1'b0;
    crd_gnt = 1'b0;
    cwr_gnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_pend &&
            (starve_cnt >= SW'(STARVE_MAX) || !vid_req)) begin
          crd_gnt = wr_n;
          cwr_gnt = ~wr_n;
          state_d = wr_n ? CRD : CWR;
        end else if (vid_req) begin
          vid_gnt = 1'b1;
          state_d = VRD;
        end
      end
      VRD:     state_d = VCAP;
      VCAP:    state_d = IDLE;
      CRD:     state_d = CCAP;
      CCAP:    state_d = IDLE;
      CWR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      cpu_done   <= 1'b0;
      vid_ack    <= 1'b0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      cpu_dout   <= '0;
      vid_data   <= '0;
      ram_ad     <= '0;
      ram_din    <= '0;
    end else begin
      state  <= state_d;
      // RAM strobes are registered: they go high in the state after grant
      ram_ce <= vid_gnt | crd_gnt | cwr_gnt;
      ram_we <= cwr_gnt;
      if (vid_gnt)
        ram_ad <= vid_addr;
      if (crd_gnt | cwr_gnt)
        ram_ad <= cpu_addr;
      if (cwr_gnt)
        ram_din <= cpu_din;

      if (crd_gnt | cwr_gnt)
        starve_cnt <= '0;
      else if (vid_gnt && cpu_pend &&
               starve_cnt < SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);

      vid_ack <= (state == VCAP);
      if (state == VCAP)
        vid_data <= ram_dout;
      if (state == CCAP)
        cpu_dout <= ram_dout;

      // a dropped strobe mid-access leaves done clear
      if (!cpu_req)
        cpu_done <= 1'b0;
      else if (state == CCAP || state == CWR)
        cpu_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a
// 1-cycle-latency BRAM model preloaded with mem[a] = a[7:0].
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, mreq_n, rd_n, wr_n;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_oe, wait_n;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_ack;
  logic        ram_ce, ram_we;
  logic [12:0] ram_ad;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int checks   = 0;
  int failures = 0;
  int acks, lowcnt, ces, good;

  logic [7:0] mem [0:8191];
  logic       mem_init = 1'b0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(13), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cs(cs), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_oe(cpu_oe), .wait_n(wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_ack(vid_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++)
        mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else if (ram_ce) begin
      if (ram_we)
        mem[ram_ad] <= ram_din;
      else
        ram_dout <= mem[ram_ad];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(string tag);
    failures++;
    $error("FAIL %s", tag);
  endtask

  task automatic idle_bus();
    cs = 1'b0; mreq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; vid_req = 1'b0;
    vid_addr = '0; cpu_addr = '0; cpu_din = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    checks++; if (ram_ce !== 1'b0) fail("rst_ram_ce");
    checks++; if (ram_we !== 1'b0) fail("rst_ram_we");
    checks++; if (vid_ack !== 1'b0) fail("rst_vid_ack");
    checks++; if (cpu_dout !== 8'h00) fail("rst_cpu_dout");
    checks++; if (vid_data !== 8'h00) fail("rst_vid_data");
    checks++; if (ram_ad !== 13'h0) fail("rst_ram_ad");
    checks++; if (wait_n !== 1'b1) fail("rst_wait_n");
    checks++; if (dut.cpu_done !== 1'b0) fail("rst_done");
    checks++; if (dut.starve_cnt !== 3'd0) fail("rst_starve");

    cs = 1'b1; mreq_n = 1'b0; wr_n = 1'b0;
    cpu_addr = 13'h0123; cpu_din = 8'hA5;
    #1;
    checks++; if (wait_n !== 1'b0) fail("wr_wait_n0");
    cyc();
    checks++; if (ram_ce !== 1'b1) fail("wr_ce");
    checks++; if (ram_we !== 1'b1) fail("wr_we");
    checks++; if (ram_ad !== 13'h0123) fail("wr_ad");
    checks++; if (ram_din !== 8'hA5) fail("wr_din");
    checks++; if (wait_n !== 1'b0) fail("wr_wait_n1");
    cyc();
    checks++; if (wait_n !== 1'b1) fail("wr_wait_n2");
    checks++; if (ram_ce !== 1'b0) fail("wr_ce_off");
    checks++; if (mem[13'h0123] !== 8'hA5) fail("wr_mem");
    idle_bus();
    cyc();
    checks++; if (dut.cpu_done !== 1'b0) fail("wr_done_clr");

    cs = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    cpu_addr = 13'h0123;
    #1;
    checks++; if (wait_n !== 1'b0) fail("rd_wait_n0");
    checks++; if (cpu_oe !== 1'b0) fail("rd_oe0");
    cyc();
    checks++; if (ram_ce !== 1'b1) fail("rd_ce");
    checks++; if (ram_we !== 1'b0) fail("rd_we");
    checks++; if (ram_ad !== 13'h0123) fail("rd_ad");
    checks++; if (wait_n !== 1'b0) fail("rd_wait_n1");
    cyc();
    checks++; if (wait_n !== 1'b0) fail("rd_wait_n2");
    cyc();
    checks++; if (wait_n !== 1'b1) fail("rd_wait_n3");
    checks++; if (cpu_dout !== 8'hA5) fail("rd_dout");
    checks++; if (cpu_oe !== 1'b1) fail("rd_oe");
    idle_bus();
    cyc();

    vid_addr = 13'h0; vid_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (vid_ack !== 1'b0) fail("vid_ack_a");
      cyc();
      checks++; if (vid_ack !== 1'b0) fail("vid_ack_b");
      cyc();
      checks++; if (vid_ack !== 1'b1) fail("vid_ack");
      checks++; if (vid_data !== 8'(i)) fail("vid_data");
      if (i == 3) vid_req = 1'b0;
      else vid_addr = 13'(i + 1);
    end
    cyc();
    checks++; if (ram_ce !== 1'b0) fail("vid_stop_ce");
    checks++; if (vid_ack !== 1'b0) fail("vid_stop_ack");

    vid_addr = 13'h0010; vid_req = 1'b1;
    cs = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    cpu_addr = 13'h1FFF;
    #1;
    checks++; if (wait_n !== 1'b0) fail("st_wait_n0");
    acks = 0; lowcnt = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      if (vid_ack) acks++;
      if (!wait_n) lowcnt++;
      if (i == 12) begin
        checks++;
        if (dut.starve_cnt !== 3'd4) fail("st_sat");
      end
    end
    cyc();
    checks++; if (wait_n !== 1'b1) fail("st_wait_n");
    checks++; if (cpu_dout !== 8'hFF) fail("st_dout");
    checks++; if (dut.starve_cnt !== 3'd0) fail("st_starve0");
    checks++; if (acks !== 4) fail("st_acks");
    checks++; if (lowcnt !== 14) fail("st_lowcnt");
    checks++; if (vid_data !== 8'h10) fail("st_vdata");
    vid_req = 1'b0;
    idle_bus();
    cyc();

    vid_addr = 13'h0002; vid_req = 1'b1;
    cs = 1'b1; mreq_n = 1'b0; wr_n = 1'b0;
    cpu_addr = 13'h0200; cpu_din = 8'h3C;
    cyc();
    checks++; if (ram_ce !== 1'b1) fail("sim_v_ce");
    checks++; if (ram_we !== 1'b0) fail("sim_v_we");
    checks++; if (ram_ad !== 13'h0002) fail("sim_v_ad");
    cyc();
    cyc();
    checks++; if (vid_ack !== 1'b1) fail("sim_ack");
    checks++; if (vid_data !== 8'h02) fail("sim_vdata");
    checks++; if (wait_n !== 1'b0) fail("sim_wait");
    vid_req = 1'b0;
    cyc();
    checks++; if (ram_we !== 1'b1) fail("sim_c_we");
    checks++; if (ram_ad !== 13'h0200) fail("sim_c_ad");
    checks++; if (ram_din !== 8'h3C) fail("sim_c_din");
    cyc();
    checks++; if (wait_n !== 1'b1) fail("sim_wait_n");
    checks++; if (mem[13'h0200] !== 8'h3C) fail("sim_mem");
    checks++; if (dut.starve_cnt !== 3'd0) fail("sim_starve");
    idle_bus();
    cyc();

    cs = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    cpu_addr = 13'h0200;
    ces = 0; good = 0;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      if (ram_ce) ces++;
      if (i >= 3 && wait_n && cpu_oe) good++;
    end
    checks++; if (ces !== 1) fail("hold_ces");
    checks++; if (good !== 11) fail("hold_good");
    checks++; if (cpu_dout !== 8'h3C) fail("hold_dout");
    rd_n = 1'b1;
    #1;
    checks++; if (cpu_oe !== 1'b0) fail("hold_oe_off");
    checks++; if (wait_n !== 1'b1) fail("hold_wait_n");
    idle_bus();
    cyc();

    cs = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    cpu_addr = 13'h0001;
    cyc();
    checks++; if (ram_ce !== 1'b1) fail("rr_crd_ce");
    reset = 1'b1;
    cyc();
    checks++; if (ram_ce !== 1'b0) fail("rr_ce");
    checks++; if (dut.cpu_done !== 1'b0) fail("rr_done");
    checks++; if (cpu_dout !== 8'h00) fail("rr_dout");
    checks++; if (wait_n !== 1'b0) fail("rr_wait_n");
    reset = 1'b0;
    cyc();
    checks++; if (ram_ce !== 1'b1) fail("rr_ce2");
    checks++; if (ram_ad !== 13'h0001) fail("rr_ad2");
    cyc();
    cyc();
    checks++; if (wait_n !== 1'b1) fail("rr_wait_n2");
    checks++; if (cpu_dout !== 8'h01) fail("rr_dout2");
    idle_bus();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
